// File: rtl/arm_fetch.sv
// arm_fetch: PC owner, imem req/gnt/rvalid front end and in-order inst FIFO.
// Define ARM_FETCH_BYPASS_EN for a zero-latency path from imem_rdata to inst.
module arm_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          halted;
  logic [31:0]   fifo_w [DEPTH];
  logic [31:0]   fifo_a [DEPTH];

  logic        grant;
  logic        drop_live;
  logic        resp_drop;
  logic        resp_out;
  logic        resp_keep;
  logic        head_valid;
  logic        byp;
  logic        push;
  logic        pop;
  logic [31:0] resp_addr;
  logic [CW:0] credit;
  logic        unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  assign credit    = {1'b0, fifo_cnt} + {1'b0, out_cnt};
  assign imem_req  = !halted && !redirect && (credit < FULL);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign drop_live = drop_cnt != '0;
  assign resp_drop = imem_rvalid && drop_live;
  assign resp_out  = imem_rvalid && !drop_live;
  assign resp_keep = resp_out && !redirect;

  // Outstanding live requests are the last out_cnt words below pc.
  assign resp_addr = pc - 32'({out_cnt, 2'b00});

  assign head_valid = fifo_cnt != '0;

`ifdef ARM_FETCH_BYPASS_EN
  assign byp = !head_valid && resp_keep;
`else
  assign byp = 1'b0;
`endif

  assign inst_valid = head_valid || byp;
  assign inst       = byp ? imem_rdata : fifo_w[rd_ptr];
  assign inst_pc    = byp ? resp_addr : fifo_a[rd_ptr];

  assign pop  = head_valid && inst_ready;
  assign push = resp_keep && !(byp && inst_ready);

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      redirect: pc_nxt = {redirect_pc[31:2], 2'b00};
      grant:    pc_nxt = pc + 32'd4;
      default:  pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc       <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      halted   <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      halted <= halted || halt;
      if (redirect) begin
        out_cnt  <= '0;
        drop_cnt <= drop_cnt + out_cnt + CW'(grant)
                    - CW'(imem_rvalid);
      end else begin
        out_cnt  <= out_cnt + CW'(grant) - CW'(resp_out);
        drop_cnt <= drop_cnt - CW'(resp_drop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_w[i] <= '0;
        fifo_a[i] <= '0;
      end
    end else if (redirect) begin
      wr_ptr   <= rd_ptr;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_w[wr_ptr] <= imem_rdata;
        fifo_a[wr_ptr] <= resp_addr;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: random imem/decode traffic against a queue-based fetch model.
// Redirects are tracked as epochs; stale-epoch responses must never surface.
module tb_arm_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef ARM_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  arm_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt),
    .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } word_t;

  mreq_t       memq[$];
  word_t       dq[$];
  logic [31:0] mpc;
  int          ep;
  bit          mhalt;
  int          cyc;
  int          total;
  int          bad;
  int          p_gnt, p_rdy, p_rv, p_redir, max_lat;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f96;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    dq.delete();
    mpc   = RESET_PC;
    ep    = 0;
    mhalt = 1'b0;
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    inst_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    idle_inputs();
    #2;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit fr, input logic [31:0] fpc,
                      input bit fh);
    bit          resp, live, byp, exp_req, exp_v, grant;
    int          live_out;
    logic [31:0] ea, ed;
    @(posedge clk);
    #1;
    cyc++;
    imem_gnt   = ($urandom_range(99) < p_gnt) && (memq.size() < 6);
    inst_ready = $urandom_range(99) < p_rdy;
    redirect   = fr || ($urandom_range(99) < p_redir);
    if (fr) redirect_pc = fpc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFFE;
    else redirect_pc = $urandom;
    halt = fh;
    resp = memq.size() > 0 && memq[0].due <= cyc
           && $urandom_range(99) < p_rv;
    imem_rvalid = resp;
    imem_rdata  = resp ? word_of(memq[0].addr) : $urandom;
    @(negedge clk);
    live_out = 0;
    foreach (memq[i]) if (memq[i].ep == ep) live_out++;
    exp_req = !mhalt && !redirect
              && (dq.size() + live_out < DEPTH);
    chk("req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("addr", imem_addr, mpc);
    live  = resp && memq[0].ep == ep && !redirect;
    byp   = BYP && dq.size() == 0 && live;
    exp_v = dq.size() > 0 || byp;
    chk("valid", 32'(inst_valid), 32'(exp_v));
    ea = '0;
    ed = '0;
    if (dq.size() > 0) begin
      ea = dq[0].addr;
      ed = dq[0].data;
    end else if (byp) begin
      ea = memq[0].addr;
      ed = word_of(ea);
    end
    if (exp_v) begin
      chk("inst", inst, ed);
      chk("inst_pc", inst_pc, ea);
    end
    grant = exp_req && imem_gnt;
    if (exp_v && inst_ready && dq.size() > 0)
      void'(dq.pop_front());
    if (resp) begin
      if (live && !(byp && inst_ready))
        dq.push_back('{addr: memq[0].addr,
                       data: word_of(memq[0].addr)});
      void'(memq.pop_front());
    end
    if (grant) begin
      memq.push_back('{addr: mpc, ep: ep,
                       due: cyc + int'($urandom_range(max_lat, 1))});
      mpc = mpc + 32'd4;
    end
    if (redirect) begin
      dq.delete();
      ep++;
      mpc = {redirect_pc[31:2], 2'b00};
    end
    mhalt = mhalt || halt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0);
  endtask

  task automatic knobs(input int g, input int r, input int v,
                       input int d, input int l);
    p_gnt   = g;
    p_rdy   = r;
    p_rv    = v;
    p_redir = d;
    max_lat = l;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_reset();
    idle_inputs();
    do_reset();

    // Streaming: single-cycle memory, decode always ready.
    knobs(100, 100, 100, 0, 1);
    run(30);

    // Backpressure: credit must cap grants at DEPTH.
    knobs(100, 0, 100, 0, 1);
    run(12);
    knobs(100, 100, 100, 0, 1);
    run(10);

    // Redirect with requests in flight, then wrap.
    knobs(100, 100, 100, 0, 3);
    run(2);
    step(1'b1, 32'h0040_0103, 1'b0);
    run(12);
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    run(12);

    knobs(70, 60, 70, 5, 4);
    run(600);

    // Halt with traffic pending; redirects must not revive fetching.
    knobs(100, 80, 80, 0, 3);
    run(3);
    step(1'b0, 32'd0, 1'b1);
    knobs(100, 70, 80, 10, 3);
    run(30);

    do_reset();
    knobs(60, 70, 60, 4, 5);
    run(600);
    knobs(100, 100, 100, 2, 1);
    run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
